priority_encoder_stream: RTL and testbench
==========================================

Name: priority_encoder_stream

Overview:
- Parametrised, registered successor to the fixed 4-to-2 encoder.
- Accepts an IN_WIDTH-bit request vector over a valid/ready handshake and emits encoded bit indices over a second valid/ready handshake.
- MODE 0 emits only the highest-priority index (single-shot). MODE 1 drains every set bit, one index per beat, in priority order.
- Sits between request-generating logic and any consumer of encoded indices; zero vectors are flagged rather than silently encoded.

Parameters:
- IN_WIDTH, 4: request vector width, must be ≥2.
- OUT_WIDTH, $clog2(IN_WIDTH): index width (derived; do not override).
- MODE, 0: 0 = single-shot priority encode; 1 = drain all set bits.
- PRIORITY_MSB, 1: 1 = highest set bit index wins first; 0 = lowest set bit index wins first.
- CNT_WIDTH, 8: width of the zero-vector statistics counter.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  request vector valid
- in_ready  output  1  block can accept a vector
- in_data  input  IN_WIDTH  request vector
- out_valid  output  1  index valid
- out_ready  input  1  consumer accepts index
- out_data  output  OUT_WIDTH  encoded index
- out_last  output  1  final beat for the current vector
- out_zero  output  1  current beat reports an all-zero vector
- zero_cnt  output  CNT_WIDTH  saturating count of zero vectors accepted

Behaviour:
- Reset: clk and reset are the only clock and reset. reset is asynchronous and active-low. While reset is low:
  - state = IDLE, pending register = 0
  - out_valid = 0, out_data = 0, out_last = 0, out_zero = 0, zero_cnt = 0
  - in_ready = 0
- Reset mid-drain discards all pending bits; no further beats are emitted after release.
- States: IDLE and EMIT.
  - in_ready = (state == IDLE) OR (out_valid AND out_ready AND out_last).
  - in_ready is combinational from out_ready; this permits back-to-back vectors.
- Accept: in_valid AND in_ready at rising edge k.
  - pending ← in_data.
  - Go to EMIT; out_valid = 1 after edge k (latency 1 cycle).
- Non-zero vector:
  - out_data = index of winning set bit per PRIORITY_MSB.
  - out_zero = 0.
  - out_last = 1 if MODE == 0, or if exactly one bit remains set in pending.
- Zero vector:
  - One beat only: out_data = 0, out_zero = 1, out_last = 1.
  - zero_cnt increments at the accept edge and saturates at all-ones; no wrap.
- Output handshake: out_valid AND out_ready at an edge consumes the beat.
  - Not last: clear the served bit from pending. The next index, with updated out_last, appears after the same edge; out_valid stays 1, giving 1 beat per cycle under continuous out_ready.
  - Last:
    - if a new vector is accepted at the same edge, load it and remain in EMIT (no bubble);
    - otherwise go to IDLE and drop out_valid to 0.
- Stability: while out_valid = 1 and out_ready = 0, out_data, out_last and out_zero hold constant.
- Input side: in_valid while in_ready = 0 is ignored; there is no buffering. in_data is sampled only on an accept edge.
- MODE 0: remaining set bits are discarded after the single beat.
- Winner selection is a combinational priority scan over pending. out_data and the flags are registered.

Test Plan:
- IN_WIDTH=4, MODE=1, PRIORITY_MSB=1, out_ready held 1; in_data=4'b1011 → beats out_data 3, 1, 0 on consecutive cycles, out_last=1 only on the index-0 beat, then out_valid=0.
- IN_WIDTH=4, MODE=0; in_data=4'b0110 → single beat out_data=2, out_last=1. Repeat with PRIORITY_MSB=0 → out_data=1.
- in_data=4'b0000 → one beat out_data=0, out_zero=1, out_last=1, zero_cnt 0→1. Apply 300 zero vectors with CNT_WIDTH=8 → zero_cnt saturates at 255.
- MODE=1, in_data=4'b1100, out_ready=0 for 5 cycles → out_data=3 held stable and in_ready=0. Then release → out_data 3, 2 with last on 2.
- Back-to-back: MODE=1, 4'b0001 then 4'b1000 with in_valid held → in_ready pulses on the last beat; outputs 0 then 3 with no idle cycle between.
- Drive reset low during the second beat of 4'b1111 → out_valid=0 immediately (asynchronously). After reset release, no residual beats; in_ready=1.

Source files
------------

// File: rtl/priority_encoder_stream.sv
`timescale 1ns/1ps
// priority_encoder_stream
//   Streaming priority encoder. Accepts an IN_WIDTH-bit request vector over a
//   valid/ready handshake and emits encoded bit indices over a second
//   valid/ready handshake. MODE 0 emits only the winning index. MODE 1 drains
//   every set bit, one index per beat, in priority order. An all-zero vector
//   produces a single flagged beat and bumps a saturating statistics counter.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   request vector valid
//   in_ready   block can accept a vector (combinational from out_ready)
//   in_data    request vector
//   out_valid  encoded index valid (registered)
//   out_ready  consumer accepts the index
//   out_data   encoded index (registered)
//   out_last   final beat for the current vector (registered)
//   out_zero   current beat reports an all-zero vector (registered)
//   zero_cnt   saturating count of accepted all-zero vectors (registered)
module priority_encoder_stream #(
  parameter int unsigned IN_WIDTH     = 4,
  parameter int unsigned OUT_WIDTH    = $clog2(IN_WIDTH),
  parameter int unsigned MODE         = 0,
  parameter int unsigned PRIORITY_MSB = 1,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 out_zero,
  output logic [CNT_WIDTH-1:0] zero_cnt
);

  // Elaboration-time sanity on the parameter set.
  if (IN_WIDTH < 2) begin : g_bad_in_width
    $error("priority_encoder_stream: IN_WIDTH must be at least 2");
  end
  if (OUT_WIDTH != $clog2(IN_WIDTH)) begin : g_bad_out_width
    $error("priority_encoder_stream: OUT_WIDTH is derived and must not be overridden");
  end
  if (MODE > 1) begin : g_bad_mode
    $error("priority_encoder_stream: MODE must be 0 or 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                state;
  state_t                state_next;

  // pending holds the bits still to be reported, including the one on out_data.
  logic [IN_WIDTH-1:0]   pending;
  logic [IN_WIDTH-1:0]   pending_next;
  logic                  out_valid_next;
  logic [OUT_WIDTH-1:0]  out_data_next;
  logic                  out_last_next;
  logic                  out_zero_next;
  logic [CNT_WIDTH-1:0]  zero_cnt_next;

  logic                  accept_c;
  logic                  out_fire_c;
  logic                  load_c;
  logic [IN_WIDTH-1:0]   scan_vec_c;
  logic [IN_WIDTH-1:0]   clear_mask_c;
  logic [OUT_WIDTH-1:0]  winner_c;
  logic                  scan_nz_c;
  logic                  scan_single_c;

  // Ready when idle, or when the final beat leaves this cycle (no bubble).
  assign in_ready   = reset & ((state == IDLE) | (out_valid & out_ready & out_last));
  assign accept_c   = in_valid & in_ready;
  assign out_fire_c = out_valid & out_ready;

  // One-hot mask of the index currently being served.
  assign clear_mask_c = IN_WIDTH'(1) << out_data;

  // Vector whose winner becomes the next registered beat: a freshly accepted
  // vector, or what remains after the served bit is retired.
  always_comb begin : p_scan_sel
    scan_vec_c = '0;
    load_c     = 1'b0;
    if (accept_c) begin
      scan_vec_c = in_data;
      load_c     = 1'b1;
    end else if (out_fire_c && !out_last) begin
      scan_vec_c = pending & ~clear_mask_c;
      load_c     = 1'b1;
    end
  end

  // Priority scan; the last match in loop order wins.
  always_comb begin : p_scan
    winner_c = '0;
    if (PRIORITY_MSB != 0) begin
      for (int i = 0; i < int'(IN_WIDTH); i++) begin
        if (scan_vec_c[i]) winner_c = OUT_WIDTH'(i);
      end
    end else begin
      for (int i = int'(IN_WIDTH) - 1; i >= 0; i--) begin
        if (scan_vec_c[i]) winner_c = OUT_WIDTH'(i);
      end
    end
  end

  assign scan_nz_c     = |scan_vec_c;
  assign scan_single_c = scan_nz_c & ((scan_vec_c & (scan_vec_c - IN_WIDTH'(1))) == '0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin : p_state_reg
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin : p_next_state
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_c) state_next = EMIT;
      end
      EMIT: begin
        if (out_fire_c && out_last) begin
          state_next = accept_c ? EMIT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the pending vector, output beat and zero counter.
  always_comb begin : p_output_next
    pending_next   = pending;
    out_valid_next = out_valid;
    out_data_next  = out_data;
    out_last_next  = out_last;
    out_zero_next  = out_zero;
    zero_cnt_next  = zero_cnt;

    if (out_fire_c && out_last) begin
      pending_next   = '0;
      out_valid_next = 1'b0;
    end

    if (load_c) begin
      pending_next   = scan_vec_c;
      out_valid_next = 1'b1;
      out_data_next  = winner_c;
      out_zero_next  = ~scan_nz_c;
      out_last_next  = (MODE == 0) | ~scan_nz_c | scan_single_c;
    end

    if (accept_c && (in_data == '0) && (zero_cnt != CNT_MAX)) begin
      zero_cnt_next = zero_cnt + CNT_WIDTH'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin : p_data_reg
    if (!reset) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_zero  <= 1'b0;
      zero_cnt  <= '0;
    end else begin
      pending   <= pending_next;
      out_valid <= out_valid_next;
      out_data  <= out_data_next;
      out_last  <= out_last_next;
      out_zero  <= out_zero_next;
      zero_cnt  <= zero_cnt_next;
    end
  end

endmodule

// File: tb/tb_priority_encoder_stream.sv
`timescale 1ns/1ps
// Testbench for priority_encoder_stream: one MODE 1 / MSB-first instance with a
// scoreboard and directed checks, plus a MODE 0 pair (MSB-first and LSB-first)
// driven in lock-step.
module tb_priority_encoder_stream;

  localparam int unsigned W  = 4;
  localparam int unsigned OW = 2;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
    logic          zero;
  } beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // MODE 1, MSB-first instance
  logic          m_in_valid  = 1'b0;
  logic          m_in_ready;
  logic [W-1:0]  m_in_data   = '0;
  logic          m_out_valid;
  logic          m_out_ready = 1'b0;
  logic [OW-1:0] m_out_data;
  logic          m_out_last;
  logic          m_out_zero;
  logic [CW-1:0] m_zero_cnt;

  // MODE 0 pair sharing one input stream
  logic          p_in_valid = 1'b0;
  logic [W-1:0]  p_in_data  = '0;
  logic          h_in_ready, h_out_valid, h_out_last, h_out_zero;
  logic          l_in_ready, l_out_valid, l_out_last, l_out_zero;
  logic [OW-1:0] h_out_data, l_out_data;
  logic [CW-1:0] h_zero_cnt, l_zero_cnt;

  priority_encoder_stream #(.IN_WIDTH(W), .MODE(1), .PRIORITY_MSB(1), .CNT_WIDTH(CW)) u_m (
    .clk(clk), .reset(reset),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
    .out_last(m_out_last), .out_zero(m_out_zero), .zero_cnt(m_zero_cnt)
  );

  priority_encoder_stream #(.IN_WIDTH(W), .MODE(0), .PRIORITY_MSB(1), .CNT_WIDTH(CW)) u_h (
    .clk(clk), .reset(reset),
    .in_valid(p_in_valid), .in_ready(h_in_ready), .in_data(p_in_data),
    .out_valid(h_out_valid), .out_ready(1'b1), .out_data(h_out_data),
    .out_last(h_out_last), .out_zero(h_out_zero), .zero_cnt(h_zero_cnt)
  );

  priority_encoder_stream #(.IN_WIDTH(W), .MODE(0), .PRIORITY_MSB(0), .CNT_WIDTH(CW)) u_l (
    .clk(clk), .reset(reset),
    .in_valid(p_in_valid), .in_ready(l_in_ready), .in_data(p_in_data),
    .out_valid(l_out_valid), .out_ready(1'b1), .out_data(l_out_data),
    .out_last(l_out_last), .out_zero(l_out_zero), .zero_cnt(l_zero_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference beat list for one vector.
  function automatic int gen(input logic [3:0] v, input bit mode, input bit msb, output beat_t b[4]);
    int n = 0;
    for (int k = 0; k < 4; k++) b[k] = '0;
    if (v == 4'd0) begin
      b[0] = {2'd0, 1'b1, 1'b1};
      return 1;
    end
    for (int k = 0; k < 4; k++) begin
      int i = msb ? 3 - k : k;
      if (v[i]) begin
        b[n] = {2'(i), 1'b0, 1'b0};
        n++;
      end
    end
    if (!mode) n = 1;
    b[n-1].last = 1'b1;
    return n;
  endfunction

  beat_t         q_m[$], q_h[$], q_l[$];
  logic [CW-1:0] exp_cnt = '0;
  logic          prev_stall = 1'b0;
  beat_t         prev_beat;
  beat_t         mb, marr[4];
  int            mn;
  beat_t         pb, parr[4];
  int            pn;

  // Scoreboard for the MODE 1 instance.
  always @(negedge clk) begin
    if (!reset) begin
      q_m.delete();
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else begin
      check("m_zero_cnt", 32'(m_zero_cnt), 32'(exp_cnt));
      if (prev_stall) begin
        check("m_hold_valid", 32'(m_out_valid), 1);
        check("m_hold_data",  32'(m_out_data), 32'(prev_beat.data));
        check("m_hold_last",  32'(m_out_last), 32'(prev_beat.last));
        check("m_hold_zero",  32'(m_out_zero), 32'(prev_beat.zero));
      end
      if (m_out_valid && m_out_ready) begin
        if (q_m.size() == 0) begin
          check("m_unexpected_beat", 1, 0);
        end else begin
          mb = q_m.pop_front();
          check("m_out_data", 32'(m_out_data), 32'(mb.data));
          check("m_out_last", 32'(m_out_last), 32'(mb.last));
          check("m_out_zero", 32'(m_out_zero), 32'(mb.zero));
        end
      end
      prev_stall = m_out_valid && !m_out_ready;
      prev_beat  = {m_out_data, m_out_last, m_out_zero};
      if (m_in_valid && m_in_ready) begin
        mn = gen(m_in_data, 1'b1, 1'b1, marr);
        for (int k = 0; k < mn; k++) q_m.push_back(marr[k]);
        if (m_in_data == '0 && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      end
    end
  end

  // Scoreboards for the MODE 0 pair.
  always @(negedge clk) begin
    if (!reset) begin
      q_h.delete();
      q_l.delete();
    end else begin
      if (h_out_valid) begin
        if (q_h.size() == 0) check("h_unexpected_beat", 1, 0);
        else begin
          pb = q_h.pop_front();
          check("h_out_data", 32'(h_out_data), 32'(pb.data));
          check("h_out_last", 32'(h_out_last), 32'(pb.last));
          check("h_out_zero", 32'(h_out_zero), 32'(pb.zero));
        end
      end
      if (l_out_valid) begin
        if (q_l.size() == 0) check("l_unexpected_beat", 1, 0);
        else begin
          pb = q_l.pop_front();
          check("l_out_data", 32'(l_out_data), 32'(pb.data));
          check("l_out_last", 32'(l_out_last), 32'(pb.last));
          check("l_out_zero", 32'(l_out_zero), 32'(pb.zero));
        end
      end
      if (p_in_valid && h_in_ready) begin
        pn = gen(p_in_data, 1'b0, 1'b1, parr);
        for (int k = 0; k < pn; k++) q_h.push_back(parr[k]);
      end
      if (p_in_valid && l_in_ready) begin
        pn = gen(p_in_data, 1'b0, 1'b0, parr);
        for (int k = 0; k < pn; k++) q_l.push_back(parr[k]);
      end
    end
  end

  // Present a vector and hold it until accepted; returns 1 ns after the accept edge.
  task automatic send_m(input logic [3:0] v);
    int t;
    m_in_valid = 1'b1;
    m_in_data  = v;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (m_in_ready) break;
    end
    if (t == 100) check("m_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    m_in_data  = 4'($urandom);
  endtask

  task automatic send_p(input logic [3:0] v);
    int t;
    p_in_valid = 1'b1;
    p_in_data  = v;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (h_in_ready) break;
    end
    if (t == 100) check("p_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    p_in_valid = 1'b0;
    p_in_data  = 4'($urandom);
  endtask

  task automatic wait_idle_m();
    int t;
    for (t = 0; t < 500; t++) begin
      @(posedge clk);
      #2;
      if (q_m.size() == 0 && !m_out_valid) break;
    end
    if (t == 500) check("m_drain_timeout", 0, 1);
  endtask

  task automatic wait_idle_p();
    int t;
    for (t = 0; t < 100; t++) begin
      @(posedge clk);
      #2;
      if (q_h.size() == 0 && q_l.size() == 0 && !h_out_valid && !l_out_valid) break;
    end
    if (t == 100) check("p_drain_timeout", 0, 1);
  endtask

  bit rnd_done;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(m_out_valid), 0);
    check("rst_in_ready",  32'(m_in_ready), 0);
    check("rst_out_data",  32'(m_out_data), 0);
    check("rst_out_last",  32'(m_out_last), 0);
    check("rst_out_zero",  32'(m_out_zero), 0);
    check("rst_zero_cnt",  32'(m_zero_cnt), 0);
    check("rst_h_valid",   32'(h_out_valid), 0);
    reset       = 1'b1;
    m_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(m_in_ready), 1);

    // Drain 1011 at full rate: 3, 1, 0 then idle.
    send_m(4'b1011);
    check("drain_b0", 32'({m_out_valid, m_out_data, m_out_last}), 32'({1'b1, 2'd3, 1'b0}));
    @(posedge clk); #1;
    check("drain_b1", 32'({m_out_valid, m_out_data, m_out_last}), 32'({1'b1, 2'd1, 1'b0}));
    @(posedge clk); #1;
    check("drain_b2", 32'({m_out_valid, m_out_data, m_out_last}), 32'({1'b1, 2'd0, 1'b1}));
    @(posedge clk); #1;
    check("drain_idle", 32'(m_out_valid), 0);
    wait_idle_m();

    // Zero vector.
    send_m(4'b0000);
    check("zero_beat", 32'({m_out_valid, m_out_data, m_out_last, m_out_zero}),
          32'({1'b1, 2'd0, 1'b1, 1'b1}));
    wait_idle_m();
    check("zero_cnt_one", 32'(m_zero_cnt), 1);

    // Back-pressure holds the beat and blocks input.
    m_out_ready = 1'b0;
    send_m(4'b1100);
    m_in_valid = 1'b1;
    m_in_data  = 4'b0101;
    repeat (5) begin
      check("stall_data",     32'(m_out_data), 3);
      check("stall_in_ready", 32'(m_in_ready), 0);
      @(posedge clk); #1;
    end
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    check("release_b0", 32'({m_out_data, m_out_last}), 32'({2'd3, 1'b0}));
    @(posedge clk); #1;
    check("release_b1", 32'({m_out_valid, m_out_data, m_out_last}), 32'({1'b1, 2'd2, 1'b1}));
    wait_idle_m();

    // Back-to-back vectors with no idle cycle.
    send_m(4'b0001);
    check("b2b_first", 32'({m_out_valid, m_out_data, m_out_last}), 32'({1'b1, 2'd0, 1'b1}));
    check("b2b_in_ready_pulse", 32'(m_in_ready), 1);
    send_m(4'b1000);
    check("b2b_second", 32'({m_out_valid, m_out_data, m_out_last}), 32'({1'b1, 2'd3, 1'b1}));
    wait_idle_m();

    // Random vectors under random back-pressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 24; k++) send_m(4'($urandom));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          m_out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_out_ready = 1'b1;
    wait_idle_m();

    // Saturate the zero counter with a continuous stream of zero vectors.
    m_in_valid = 1'b1;
    m_in_data  = 4'b0000;
    repeat (300) @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    wait_idle_m();
    check("zero_cnt_sat", 32'(m_zero_cnt), 255);

    // MODE 0 pair: MSB-first and LSB-first single-shot.
    send_p(4'b0110);
    check("m0_msb_0110", 32'({h_out_valid, h_out_data, h_out_last}), 32'({1'b1, 2'd2, 1'b1}));
    check("m0_lsb_0110", 32'({l_out_valid, l_out_data, l_out_last}), 32'({1'b1, 2'd1, 1'b1}));
    send_p(4'b1011);
    send_p(4'b0000);
    send_p(4'b1000);
    for (int k = 0; k < 8; k++) send_p(4'($urandom));
    wait_idle_p();

    // Reset during the second beat of 1111.
    send_m(4'b1111);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(m_out_valid), 0);
    check("midrst_in_ready",  32'(m_in_ready), 0);
    check("midrst_zero_cnt",  32'(m_zero_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_valid",    32'(m_out_valid), 0);
      check("post_rst_in_ready", 32'(m_in_ready), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
